// File: rtl/result_drain_pkg.sv
// Shared sizes, index type and drain FSM encoding for the systolic-array result drain.
package result_drain_pkg;
    localparam int unsigned N      = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [1:0]       drain_state_t;

    localparam drain_state_t ST_IDLE  = 2'd0;
    localparam drain_state_t ST_FILL  = 2'd1;
    localparam drain_state_t ST_DRAIN = 2'd2;
endpackage

// File: rtl/result_drain_if.sv
// Row-input and element-output handshakes of the result drain.
interface result_drain_if;
    import result_drain_pkg::*;

    logic                res_valid;
    logic                res_ready;
    logic [N*ACC_W-1:0]  res_row;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   data_out;
    idx_t                out_row;
    idx_t                out_col;
    logic                out_last;
    logic                done;

    modport master (
        output res_valid, res_row, out_ready,
        input  res_ready, out_valid, data_out, out_row, out_col, out_last, done
    );

    modport slave (
        input  res_valid, res_row, out_ready,
        output res_ready, out_valid, data_out, out_row, out_col, out_last, done
    );
endinterface

// File: rtl/result_drain_sat_trunc.sv
// Narrows a signed accumulator: clamp to the signed output range, or keep the low bits.
module sat_trunc
    import result_drain_pkg::*;
#(
    parameter int unsigned IN_W     = ACC_W,
    parameter int unsigned OUT_W    = DATA_W,
    parameter bit          SATURATE = 1'b1
) (
    input  logic [IN_W-1:0]  acc_i,
    output logic [OUT_W-1:0] dat_c
);
    logic [IN_W-OUT_W:0] hi_c;
    logic                ovf_c;

    // Overflow when the bits above the output sign are not all copies of it.
    always_comb begin
        hi_c  = acc_i[IN_W-1:OUT_W-1];
        ovf_c = !((&hi_c) || !(|hi_c));
        dat_c = acc_i[OUT_W-1:0];
        if (SATURATE && ovf_c) begin
            dat_c = {acc_i[IN_W-1], {(OUT_W-1){~acc_i[IN_W-1]}}};
        end
    end
endmodule

// File: rtl/result_drain.sv
// Result drain: buffers an NxN accumulator matrix one row per cycle, then
// streams narrowed elements row-major on a back-pressurable valid/ready port.
module result_drain
    import result_drain_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    result_drain_if.slave bus
);
    localparam idx_t LAST_IDX = idx_t'(N - 1);

    drain_state_t      state_q, state_d;
    idx_t              wr_row_q, wr_row_d;
    logic              res_ready_q, res_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    idx_t              out_row_q, out_row_d;
    idx_t              out_col_q, out_col_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;

    logic [ACC_W-1:0]  mem_q [N][N];
    logic              row_acc_c;
    logic              out_hs_c;
    idx_t              rd_row_c;
    idx_t              rd_col_c;
    logic [ACC_W-1:0]  rd_acc_c;
    logic [DATA_W-1:0] sat_c;

    assign row_acc_c = bus.res_valid & res_ready_q & en;
    assign out_hs_c  = out_valid_q & bus.out_ready & en;

    // Element to load next: (0,0) when entering DRAIN, else successor of the current one.
    always_comb begin
        rd_row_c = '0;
        rd_col_c = '0;
        if (state_q == ST_DRAIN) begin
            if (out_col_q == LAST_IDX) begin
                rd_row_c = idx_t'(out_row_q + 1'b1);
            end else begin
                rd_row_c = out_row_q;
                rd_col_c = idx_t'(out_col_q + 1'b1);
            end
        end
    end

    assign rd_acc_c = mem_q[rd_row_c][rd_col_c];

    sat_trunc #(
        .IN_W     (ACC_W),
        .OUT_W    (DATA_W),
        .SATURATE (SATURATE)
    ) u_sat (
        .acc_i (rd_acc_c),
        .dat_c (sat_c)
    );

    always_comb begin
        state_d     = state_q;
        wr_row_d    = wr_row_q;
        res_ready_d = res_ready_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        done_d      = done_q;
        if (en) begin
            done_d = 1'b0;
            case (state_q)
                ST_IDLE, ST_FILL: begin
                    if (row_acc_c) begin
                        state_d  = ST_FILL;
                        wr_row_d = (wr_row_q == LAST_IDX) ? '0 : idx_t'(wr_row_q + 1'b1);
                        if (wr_row_q == LAST_IDX) begin
                            state_d     = ST_DRAIN;
                            res_ready_d = 1'b0;
                            out_valid_d = 1'b1;
                            data_out_d  = sat_c;
                            out_row_d   = rd_row_c;
                            out_col_d   = rd_col_c;
                            out_last_d  = (rd_row_c == LAST_IDX) && (rd_col_c == LAST_IDX);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_hs_c) begin
                        if (out_last_q) begin
                            state_d     = ST_IDLE;
                            res_ready_d = 1'b1;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            out_row_d   = '0;
                            out_col_d   = '0;
                            done_d      = 1'b1;
                        end else begin
                            data_out_d = sat_c;
                            out_row_d  = rd_row_c;
                            out_col_d  = rd_col_c;
                            out_last_d = (rd_row_c == LAST_IDX) && (rd_col_c == LAST_IDX);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_row_q    <= '0;
            res_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_row_q    <= wr_row_d;
            res_ready_q <= res_ready_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    // Matrix storage needs no reset: nothing is read out before all N rows land.
    always_ff @(posedge clk) begin
        if (row_acc_c) begin
            for (int c = 0; c < N; c++) begin
                mem_q[wr_row_q][c] <= bus.res_row[c*ACC_W +: ACC_W];
            end
        end
    end

    assign bus.res_ready = res_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: random matrices against a matrix/element-level model,
// with a second, truncating instance sharing the same stimulus.
`timescale 1ns/1ps
module tb_result_drain;
    import result_drain_pkg::*;

    localparam int NN = N * N;
    typedef logic [N*ACC_W-1:0] row_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    always #5 clk = ~clk;

    result_drain_if bus ();
    result_drain_if bus_t ();

    result_drain #(.SATURATE(1'b1)) u_dut   (.clk(clk), .rst_n(rst_n), .en(en), .bus(bus));
    result_drain #(.SATURATE(1'b0)) u_trunc (.clk(clk), .rst_n(rst_n), .en(en), .bus(bus_t));

    assign bus_t.res_valid = bus.res_valid;
    assign bus_t.res_row   = bus.res_row;
    assign bus_t.out_ready = bus.out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    row_t   feed_q[$];
    longint m_mat[NN];
    int     m_rows = 0, m_idx = 0, hs_count = 0, done_pulses = 0, cyc = 0;
    bit     m_drain = 1'b0, m_done = 1'b0, chk_on = 1'b0, prev_done = 1'b0;
    logic [DATA_W-1:0] cap[NN];
    logic [DATA_W-1:0] cap_t[NN];
    logic [DATA_W-1:0] cap1[NN];
    row_t   mat_a[N];
    int     en_off0 = -1, en_off1 = -1, rdy_mode = 0;
    bit     vld_rand = 1'b0, en_rand = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_sat(input longint v);
        longint hi = (longint'(1) <<< (DATA_W - 1)) - 1;
        longint lo = -(longint'(1) <<< (DATA_W - 1));
        logic [63:0] t = v;
        if (v > hi) return {1'b0, {(DATA_W-1){1'b1}}};
        if (v < lo) return {1'b1, {(DATA_W-1){1'b0}}};
        return t[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] exp_trunc(input longint v);
        logic [63:0] t = v;
        return t[DATA_W-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] rand_acc();
        case ($urandom_range(0, 3))
            0: return ACC_W'($urandom_range(0, 2000)) - ACC_W'(1000);
            1: return ACC_W'($urandom());
            2: return ACC_W'(32'h0000_7FFD) + ACC_W'($urandom_range(0, 4));
            default: return ACC_W'(32'hFFFF_7FFE) + ACC_W'($urandom_range(0, 4));
        endcase
    endfunction

    // Model: rows fill a matrix; once full, elements leave in row-major order.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_rows = 0; m_idx = 0; m_drain = 1'b0; m_done = 1'b0;
        end else if (en) begin
            m_done = 1'b0;
            if (!m_drain) begin
                if (bus.res_valid) begin
                    for (int c = 0; c < N; c++)
                        m_mat[m_rows*N + c] = longint'($signed(bus.res_row[c*ACC_W +: ACC_W]));
                    if (feed_q.size() > 0) void'(feed_q.pop_front());
                    m_rows++;
                    if (m_rows == N) begin m_rows = 0; m_drain = 1'b1; m_idx = 0; end
                end
            end else if (bus.out_ready) begin
                hs_count++;
                if (m_idx == NN - 1) begin m_drain = 1'b0; m_done = 1'b1; end
                else m_idx++;
            end
        end
    end

    // Compare process: control every cycle, element fields whenever valid.
    initial forever begin
        @(negedge clk);
        if (rst_n && chk_on) begin
            check("res_ready", bus.res_ready, !m_drain);
            check("out_valid", bus.out_valid, m_drain);
            check("done", bus.done, m_done);
            check("t_ctrl", {bus_t.res_ready, bus_t.out_valid, bus_t.done}, {!m_drain, m_drain, m_done});
            if (m_drain) begin
                check("data_out", bus.data_out, exp_sat(m_mat[m_idx]));
                check("out_row", bus.out_row, m_idx / N);
                check("out_col", bus.out_col, m_idx % N);
                check("out_last", bus.out_last, m_idx == NN - 1);
                check("t_data", bus_t.data_out, exp_trunc(m_mat[m_idx]));
                check("t_pos", {bus_t.out_last, bus_t.out_row, bus_t.out_col},
                      {m_idx == NN - 1, IDX_W'(m_idx / N), IDX_W'(m_idx % N)});
                cap[m_idx]   = bus.data_out;
                cap_t[m_idx] = bus_t.data_out;
            end
            if (bus.done && !prev_done) done_pulses++;
            prev_done = bus.done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic drive_cycle();
        en = !((en_off0 >= 0 && cyc >= en_off0 && cyc < en_off0 + 10) ||
               (en_off1 >= 0 && cyc >= en_off1 && cyc < en_off1 + 10) ||
               (en_rand && $urandom_range(0, 4) == 0));
        case (rdy_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = ((cyc / 3) % 2) == 0;
            default: bus.out_ready = $urandom_range(0, 3) != 0;
        endcase
        if (feed_q.size() > 0 && (!vld_rand || $urandom_range(0, 3) != 0)) begin
            bus.res_valid = 1'b1;
            bus.res_row   = feed_q[0];
        end else begin
            bus.res_valid = 1'b0;
            for (int c = 0; c < N; c++) bus.res_row[c*ACC_W +: ACC_W] = ACC_W'($urandom());
        end
        cyc++;
    endtask

    task automatic run_until_idle(input string nm, input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            drive_cycle();
            k++;
        end while (!(feed_q.size() == 0 && !m_drain) && k < budget);
        check({nm, "_timeout"}, k >= budget, 0);
        en_off0 = -1; en_off1 = -1; en_rand = 1'b0; vld_rand = 1'b0; rdy_mode = 0;
        @(negedge clk); drive_cycle();
    endtask

    task automatic push_random();
        row_t r;
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < N; c++) r[c*ACC_W +: ACC_W] = rand_acc();
            feed_q.push_back(r);
        end
    endtask

    task automatic check_reset(input string nm);
        check({nm, "_ready"}, bus.res_ready, 1);
        check({nm, "_valid"}, bus.out_valid, 0);
        check({nm, "_data"},  bus.data_out, 0);
        check({nm, "_row"},   bus.out_row, 0);
        check({nm, "_col"},   bus.out_col, 0);
        check({nm, "_last"},  bus.out_last, 0);
        check({nm, "_done"},  bus.done, 0);
    endtask

    initial begin
        int r0[8] = '{16, 34, 26, 27, 27, 13, 12, 26};
        int r7[8] = '{24, 59, 53, 39, 46, 51, 40, 44};
        logic [ACC_W-1:0] s0[4] = '{32'h0001_2345, 32'hFFFE_EE90, 32'h0000_7FFF, 32'hFFFF_8000};
        row_t r;
        int   k;

        bus.res_valid = 1'b0; bus.res_row = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1; en = 1'b1; chk_on = 1'b1;

        // 1: array result matrix, consumer always ready
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < N; c++) begin
                if (i == 0)          r[c*ACC_W +: ACC_W] = ACC_W'(r0[c]);
                else if (i == N - 1) r[c*ACC_W +: ACC_W] = ACC_W'(r7[c]);
                else                 r[c*ACC_W +: ACC_W] = ACC_W'($urandom_range(0, 99));
            end
            mat_a[i] = r;
            feed_q.push_back(r);
        end
        done_pulses = 0;
        run_until_idle("t1", 300);
        check("t1_first", cap[0], 16);
        check("t1_last", cap[NN-1], 44);
        check("t1_done_pulses", done_pulses, 1);
        cap1 = cap;

        // 2: saturation versus truncation
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < N; c++)
                r[c*ACC_W +: ACC_W] = (i == 0) ? ((c < 4) ? s0[c] : '0) : rand_acc();
            feed_q.push_back(r);
        end
        run_until_idle("t2", 300);
        check("t2_sat0", cap[0], 16'h7FFF);
        check("t2_sat1", cap[1], 16'h8000);
        check("t2_sat2", cap[2], 16'h7FFF);
        check("t2_sat3", cap[3], 16'h8000);
        check("t2_trunc0", cap_t[0], 16'h2345);
        check("t2_trunc1", cap_t[1], 16'hEE90);

        // 3: back-pressure every 3 cycles
        k = hs_count;
        push_random(); rdy_mode = 1; cyc = 0;
        run_until_idle("t3", 400);
        check("t3_handshakes", hs_count - k, NN);

        // 4: next matrix held valid during the drain of the previous one
        push_random(); push_random(); rdy_mode = 2; done_pulses = 0;
        run_until_idle("t4", 800);
        check("t4_done_pulses", done_pulses, 2);

        // 5: asynchronous reset at element (3,5), then a clean matrix
        push_random(); rdy_mode = 0; k = 0;
        do begin
            @(negedge clk); drive_cycle(); k++;
        end while (!(m_drain && m_idx == 3*N + 5) && k < 400);
        check("t5_reach", k < 400, 1);
        #2 rst_n = 1'b0;
        #1 check_reset("t5_abort");
        feed_q.delete(); bus.res_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_random();
        run_until_idle("t5", 300);

        // 6: enable dropped mid-fill and mid-drain; stream must match test 1
        for (int i = 0; i < N; i++) feed_q.push_back(mat_a[i]);
        cyc = 0; en_off0 = 3; en_off1 = 30; done_pulses = 0;
        run_until_idle("t6", 400);
        for (int i = 0; i < NN; i++) check("t6_stream", cap[i], cap1[i]);
        check("t6_done_pulses", done_pulses, 1);

        // 7: random enable, valid gaps and ready
        push_random(); push_random();
        en_rand = 1'b1; vld_rand = 1'b1; rdy_mode = 2;
        run_until_idle("t7", 1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
